// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_arbiter (with internal add_sub_32 datapath)
//  Purpose  : Shares a single add/subtract datapath between two requesters.
//             Each requester uses a valid/ready handshake. A round-robin
//             arbiter picks the winner. Its operands are latched, run through
//             the ripple adder, and the registered result is returned on a
//             valid/ready response channel tagged with the requester ID.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             req0_* / req1_*     - valid, ready, a, b, sub per requester
//             rsp_valid/rsp_ready - response handshake
//             rsp_id, rsp_sum, rsp_cout, rsp_ovf, rsp_zero - result fields
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  add_sub_32 : N-bit ripple-carry adder/subtractor.
//  sum = a + (b ^ {N{sel}}) + cin. With sel = cin = 1 this computes a - b.
// ----------------------------------------------------------------------------
module add_sub_32 #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_sel,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N:0]   w_c;
  logic [N-1:0] w_bx;

  assign w_c[0] = i_cin;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ripple
      assign w_bx[gi]    = i_b[gi] ^ i_sel;
      assign o_sum[gi]   = i_a[gi] ^ w_bx[gi] ^ w_c[gi];
      assign w_c[gi + 1] = (i_a[gi] & w_bx[gi]) | (w_c[gi] & (i_a[gi] ^ w_bx[gi]));
    end
  endgenerate

  assign o_cout = w_c[N];

endmodule

// ----------------------------------------------------------------------------
//  addsub_arbiter : top level
// ----------------------------------------------------------------------------
module addsub_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req0_sub,

  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic         req1_sub,

  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_sum,
  output logic         rsp_cout,
  output logic         rsp_ovf,
  output logic         rsp_zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_next;

  // Operand registers: the adder sees only these, never the live inputs.
  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic         r_sub;
  logic         r_id;

  // Requester granted on the most recent accept.
  logic         r_last;

  // Result registers.
  logic [N-1:0] r_sum;
  logic         r_cout;
  logic         r_ovf;
  logic         r_zero;
  logic         r_rid;

  logic         w_acc;
  logic         w_gnt;
  logic         w_accept;

  logic [N-1:0] w_sum;
  logic         w_cout;
  logic [N-1:0] w_bx;
  logic         w_ovf;

  // --------------------------------------------------------------------------
  // Shared datapath
  // --------------------------------------------------------------------------
  add_sub_32 #(.N(N)) u_add_sub (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_sel  (r_sub),
    .i_cin  (r_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // Overflow is judged against the effective (possibly inverted) b operand.
  assign w_bx  = r_b ^ {N{r_sub}};
  assign w_ovf = (r_a[N-1] == w_bx[N-1]) && (w_sum[N-1] != r_a[N-1]);

  // --------------------------------------------------------------------------
  // Next state, arbitration and ready generation
  // --------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_acc      = 1'b0;
    w_gnt      = ~r_last;
    w_accept   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    // Accept window: idle, or the held result is leaving this cycle so the
    // result registers free up at the same edge a new operation is latched.
    case (r_state)
      ST_IDLE: w_acc = 1'b1;
      ST_RESP: w_acc = rsp_ready;
      default: w_acc = 1'b0;
    endcase

    // Nothing may complete during a reset cycle.
    if (rst) begin
      w_acc = 1'b0;
    end

    // A lone valid requester wins outright. Otherwise the one not granted
    // last wins. With no valid requester the pointer choice is kept so only
    // one ready is ever high.
    if (req0_valid && !req1_valid) begin
      w_gnt = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      w_gnt = 1'b1;
    end else begin
      w_gnt = ~r_last;
    end

    req0_ready = w_acc && (w_gnt == 1'b0);
    req1_ready = w_acc && (w_gnt == 1'b1);
    w_accept   = (req0_ready && req0_valid) || (req1_ready && req1_valid);

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_next = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_next = w_accept ? ST_EXEC : ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Operand latch and grant pointer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sub  <= 1'b0;
      r_id   <= 1'b0;
      r_last <= 1'b1;
    end else if (w_accept) begin
      r_last <= w_gnt;
      r_id   <= w_gnt;
      if (w_gnt) begin
        r_a   <= req1_a;
        r_b   <= req1_b;
        r_sub <= req1_sub;
      end else begin
        r_a   <= req0_a;
        r_b   <= req0_b;
        r_sub <= req0_sub;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result registers: loaded only in EXEC, so they hold steady throughout
  // RESP regardless of what the requesters do.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      r_rid  <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
      r_zero <= ~|w_sum;
      r_rid  <= r_id;
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_id    = r_rid;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign rsp_ovf   = r_ovf;
  assign rsp_zero  = r_zero;

endmodule
`default_nettype wire
